// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the core's memRead/memWrite strobes.
// Serves word loads/stores from an on-chip array after LATENCY wait cycles,
// holds the core with a combinational stall, and flags illegal requests.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        stall,
    output logic        done,
    output logic        fault
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_INIT    = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic             is_store_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [31:0]      wdata_reg;
    logic [31:0]      read_data_reg;
    logic             done_reg;
    logic             fault_reg;

    // Word storage; deliberately not reset so contents survive rst.
    logic [31:0] mem [DEPTH_WORDS];

    logic req;
    logic illegal;
    logic latch_en;
    logic finish;
    logic fault_next;

    assign req     = memRead | memWrite;
    assign illegal = (memRead & memWrite) | (addr[1:0] != 2'b00) | (addr[31:2] >= DEPTH_LIMIT);

    // Next-state, counter and stall decode; stall is forced low during reset.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall      = 1'b0;
        latch_en   = 1'b0;
        finish     = 1'b0;
        fault_next = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = req;
                if (req) begin
                    if (illegal) begin
                        fault_next = 1'b1;
                        state_next = RESP;
                    end else begin
                        latch_en   = 1'b1;
                        cnt_next   = LAT_INIT;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    finish     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // State, counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            done_reg      <= 1'b0;
            fault_reg     <= 1'b0;
            read_data_reg <= 32'h0000_0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= (state_next == RESP);
            fault_reg <= fault_next;
            if (fault_next) begin
                read_data_reg <= 32'h0000_0000;
            end else if (finish && !is_store_reg) begin
                read_data_reg <= mem[idx_reg];
            end
        end
    end

    // Request capture; the latched copy is what the access uses from BUSY on.
    always_ff @(posedge clk) begin
        if (latch_en && !rst) begin
            is_store_reg <= memWrite;
            idx_reg      <= addr[IDX_W+1:2];
            wdata_reg    <= writeData;
        end
    end

    // Array write at the end of the wait; reset aborts a pending store.
    always_ff @(posedge clk) begin
        if (!rst && finish && is_store_reg) begin
            mem[idx_reg] <= wdata_reg;
        end
    end

    assign readData = read_data_reg;
    assign done     = done_reg;
    assign fault    = fault_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with LATENCY=2 (index 0) and one
// with LATENCY=0 (index 1), each checked against a word-array reference model.
module tb_dmem_responder;

    logic        clk;
    logic        rst_s   [2];
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_o [2];
    logic        stall_o [2];
    logic        done_o  [2];
    logic        fault_o [2];

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] model_mem [2][256];
    logic [31:0] model_rd  [2];

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst_s[0]), .memRead(rd_s[0]), .memWrite(wr_s[0]),
        .addr(addr_s[0]), .writeData(wdata_s[0]), .readData(rdata_o[0]),
        .stall(stall_o[0]), .done(done_o[0]), .fault(fault_o[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst_s[1]), .memRead(rd_s[1]), .memWrite(wr_s[1]),
        .addr(addr_s[1]), .writeData(wdata_s[1]), .readData(rdata_o[1]),
        .stall(stall_o[1]), .done(done_o[1]), .fault(fault_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One core access; called at a falling edge, returns at a falling edge.
    task automatic access(input int d, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd, input bit mutate);
        int lat, exp_cyc, cyc, got, stall_cnt;
        bit bad;
        logic [31:0] exp_rd, rd_seen;
        logic f_seen;
        lat     = (d == 0) ? 2 : 0;
        bad     = (r && w) || (a[1:0] != 2'b00) || (a[31:2] >= 256);
        exp_cyc = bad ? 1 : lat + 2;
        if (bad)    exp_rd = 32'h0;
        else if (r) exp_rd = model_mem[d][a[9:2]];
        else        exp_rd = model_rd[d];
        if (!bad && w) model_mem[d][a[9:2]] = wd;
        model_rd[d] = exp_rd;

        rd_s[d] = r; wr_s[d] = w; addr_s[d] = a; wdata_s[d] = wd;
        cyc = 0; got = -1; stall_cnt = 0; rd_seen = 32'h0; f_seen = 1'b0;
        while (cyc < 40 && got < 0) begin
            #1;
            if (stall_o[d] === 1'b1) stall_cnt++;
            if (done_o[d] === 1'b1) begin
                got = cyc; rd_seen = rdata_o[d]; f_seen = fault_o[d];
            end
            @(negedge clk);
            cyc++;
            if (mutate && cyc == 1) begin
                addr_s[d]  = {$urandom_range(0, 255), 2'b00} ^ 32'h4;
                wdata_s[d] = $urandom;
            end
        end
        rd_s[d] = 1'b0; wr_s[d] = 1'b0;
        check("done_cycle", 32'(got), 32'(exp_cyc));
        check("stall_cycles", 32'(stall_cnt), 32'(exp_cyc));
        check("fault", {31'h0, f_seen}, {31'h0, bad});
        check("readData", rd_seen, exp_rd);
        $display("txn dut=%0d rd=%0b wr=%0b addr=%h wdata=%h -> done@%0d fault=%0b readData=%h",
                 d, r, w, a, wd, got, f_seen, rd_seen);
    endtask

    // Store interrupted by a reset pulse in the given cycle of the access.
    task automatic store_reset(input int d, input logic [31:0] a, input logic [31:0] wd, input int rst_cyc);
        rd_s[d] = 1'b0; wr_s[d] = 1'b1; addr_s[d] = a; wdata_s[d] = wd;
        for (int c = 0; c < rst_cyc; c++) @(negedge clk);
        rst_s[d] = 1'b1; wr_s[d] = 1'b0;
        #1 check("stall_in_rst", {31'h0, stall_o[d]}, 32'h0);
        @(negedge clk);
        rst_s[d] = 1'b0;
        #1;
        check("done_after_rst", {31'h0, done_o[d]}, 32'h0);
        check("rdata_after_rst", rdata_o[d], 32'h0);
        model_rd[d] = 32'h0;
        $display("txn dut=%0d store addr=%h wdata=%h reset in cycle %0d", d, a, wd, rst_cyc);
        @(negedge clk);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; rd_s[d] = 1'b1; wr_s[d] = 1'b0;
            addr_s[d] = 32'h12; wdata_s[d] = 32'h0; model_rd[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_readData", rdata_o[d], 32'h0);
            check("rst_done", {31'h0, done_o[d]}, 32'h0);
            check("rst_fault", {31'h0, fault_o[d]}, 32'h0);
            check("rst_stall", {31'h0, stall_o[d]}, 32'h0);
        end
        @(negedge clk);
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        #1;
        check("release_stall0", {31'h0, stall_o[0]}, 32'h1);
        check("release_stall1", {31'h0, stall_o[1]}, 32'h1);
        // Misaligned LW pending across reset release is faulted in both.
        access(0, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0);
        access(1, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0);

        // Give every word a known value.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                access(d, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

        // SW/LW, FSW/FLW top word, no aliasing with word 0.
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        access(0, 1'b0, 1'b1, 32'h3FC, 32'h3F800000, 1'b0);
        access(0, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Faults.
        access(0, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0);
        access(0, 1'b0, 1'b1, 32'h400, 32'hFFFFFFFF, 1'b0);
        access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        access(0, 1'b1, 1'b1, 32'h8, 32'h1, 1'b0);
        access(1, 1'b1, 1'b1, 32'h8, 32'h1, 1'b0);

        // Reset mid-store, including the final wait cycle.
        store_reset(0, 32'h20, 32'h12345678, 2);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        store_reset(0, 32'h24, 32'hCAFEF00D, 3);
        access(0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0);
        store_reset(1, 32'h20, 32'h12345678, 1);
        access(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

        // Mid-access address/data changes are ignored.
        access(1, 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b1);
        access(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
        access(0, 1'b0, 1'b1, 32'h44, 32'h5A5A5A5A, 1'b1);
        access(0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1);

        // Randomized mix of legal and illegal accesses.
        for (int n = 0; n < 300; n++) begin
            int d, kind;
            logic r, w;
            logic [31:0] a;
            d    = n % 2;
            kind = $urandom_range(0, 9);
            r    = $urandom_range(0, 1) == 1;
            w    = !r;
            a    = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if (kind == 0)      a[1:0] = 2'($urandom_range(1, 3));
            else if (kind == 1) a = a + 32'h400 + ($urandom & 32'hFFFF_F000);
            else if (kind == 2) begin r = 1'b1; w = 1'b1; end
            access(d, r, w, a, $urandom, $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I/F core: the slave end of the `memRead`/`memWrite` strobes driven by the control unit. It serves integer and FP loads/stores (LW/SW/FLW/FSW) from a word-addressed on-chip array, inserting a programmable number of wait states. While an access is outstanding it raises `stall` so the core holds PC and the request. Illegal requests are reported with `fault` and never touch the array.

## Interface
- `DEPTH_WORDS`, default 256: array depth in 32-bit words; power of two, 16..4096.
- `LATENCY`, default 2: wait cycles in BUSY, 0..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `memRead` in 1: load request (LW/FLW), from control unit.
- `memWrite` in 1: store request (SW/FSW), from control unit.
- `addr` in 32: byte address (ALU result).
- `writeData` in 32: store data (integer or FP register rs2).
- `readData` out 32: load data, registered.
- `stall` out 1: combinational; core must hold PC, `addr`, `writeData` and strobes while high.
- `done` out 1: registered one-cycle completion pulse.
- `fault` out 1: registered; high together with `done` when the request was illegal.

## Operation
- `req` = `memRead | memWrite`.
- Illegal request if any of the following holds:
  - both strobes are high;
  - `addr[1:0] != 0`;
  - `addr[31:2] >= DEPTH_WORDS`.
- IDLE:
  - `stall = req`.
  - On a legal `req`: latch op, word index and `writeData`; load `cnt <= LATENCY`; go to BUSY.
  - On an illegal `req`: go to RESP with the fault flag set; no latch into the array.
- BUSY:
  - `stall = 1`.
  - While `cnt != 0`: `cnt <= cnt - 1`.
  - When `cnt == 0`:
    - store: `mem[idx] <= wdata_latched`;
    - load: `readData <= mem[idx]`;
    - go to RESP.
- RESP:
  - `stall = 0` and `done = 1`.
  - `fault = 1` only for an illegal request; in that case `readData <= 0`.
  - Always go to IDLE next cycle. The core retires the instruction on this edge.
- `readData` holds its last value except when a load completes or a fault is reported.
- Strobes are ignored in BUSY and RESP. The latched copy is authoritative; mid-access changes of `addr`/`writeData` have no effect.
- The array is not reset. Contents persist across `rst`.

## Timing
- Reset values: state IDLE, `cnt` 0, `readData` 0x00000000, `done` 0, `fault` 0. While `rst` is high, `stall` = 0.
- Legal access, with the request first visible at cycle 0 in IDLE:
  - BUSY occupies cycles 1..LATENCY+1;
  - RESP occurs at cycle LATENCY+2;
  - `stall` is high for LATENCY+2 cycles;
  - `readData` is valid from cycle LATENCY+2.
- Illegal access: RESP at cycle 1 and `stall` high for 1 cycle, independent of LATENCY.
- LATENCY=0: BUSY lasts exactly 1 cycle.
- Back-to-back requests: after RESP, the next request is sampled in IDLE the following cycle. There is one dead cycle minimum between accesses, and no bubble is created in the core because `stall` is combinational.
- Reset asserted in BUSY: the access is aborted and a pending store is not written. If reset coincides with the `cnt == 0` cycle, reset wins and no write occurs.
- Reset asserted in RESP: `done`/`fault` go to 0 on the next edge.
- Read-after-write to the same word returns the new data, because accesses are serialized.

## Test plan
- **Reset:** hold `rst` 3 cycles with `memRead=1` → `readData` 0, `done` 0, `fault` 0, `stall` 0. Release `rst` → `stall` 1 in the same cycle.
- **SW then LW, LATENCY=2:** SW `addr` 0x10, data 0xDEADBEEF → `stall` high 4 cycles, `done` at cycle 4. Then LW 0x10 → `readData` 0xDEADBEEF at cycle 4 of the load.
- **FSW/FLW, top word:** FSW 0x3F800000 to `addr` 0x3FC (word 255) → FLW returns 0x3F800000. A load from word 0 still returns its earlier value, proving no aliasing.
- **Faults:**
  - LW at 0x12 (misaligned) → `fault`+`done` at cycle 1, `readData` 0.
  - SW at 0x400 (out of range) → fault; a subsequent LW 0x0 is unchanged.
  - Both strobes high → fault.
- **Reset mid-store:** SW 0x20 data 0x12345678, `rst` pulsed in BUSY cycle 2 → a later LW 0x20 returns the prior contents, not 0x12345678.
- **LATENCY=0 and request change:** change `addr` during BUSY → access uses the latched address. With LATENCY=0, `stall` is high exactly 2 cycles per legal access.
